// File: rtl/vga_row_decoder.sv
// vga_row_decoder: maps a column occupancy word to the VGA row of its topmost occupied cell
// Registered outputs with a one-cycle valid pulse and empty/full/gap status flags.
module vga_row_decoder #(
    parameter int ROWS  = 6,
    parameter int ROW_W = 3,
    parameter int COL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [ROWS-1:0]  onoff,
    input  logic [COL_W-1:0] col_in,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             row_valid,
    output logic             empty,
    output logic             full,
    output logic             gap_err
);
    logic [ROW_W-1:0] row_n;
    logic [ROWS-1:0]  onoff_inc;
    always_comb begin
        row_n = '1;
        for (int i = 0; i < ROWS; i++)
            if (onoff[i]) row_n = ROW_W'(ROWS - 1 - i);
    end
    // a contiguous fill from the bottom is 2**k-1, so adding one clears every set bit
    assign onoff_inc = onoff + {{(ROWS-1){1'b0}}, 1'b1};
    always_ff @(posedge clk) begin
        if (!reset) begin
            row       <= '1;
            col       <= '0;
            row_valid <= 1'b0;
            empty     <= 1'b1;
            full      <= 1'b0;
            gap_err   <= 1'b0;
        end else begin
            row_valid <= go;
            if (go) begin
                row     <= row_n;
                col     <= col_in;
                empty   <= onoff == '0;
                full    <= &onoff;
                gap_err <= |(onoff & onoff_inc);
            end
        end
    end
endmodule

// File: tb/tb_vga_row_decoder.sv
// tb_vga_row_decoder: directed vectors with hand-computed expectations
module tb_vga_row_decoder;
    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [5:0] onoff;
    logic [2:0] col_in;
    logic [2:0] row;
    logic [2:0] col;
    logic       row_valid;
    logic       empty;
    logic       full;
    logic       gap_err;
    int         n_run = 0;
    int         n_fail = 0;

    vga_row_decoder dut (
        .clk(clk), .reset(reset), .go(go), .onoff(onoff), .col_in(col_in),
        .row(row), .col(col), .row_valid(row_valid),
        .empty(empty), .full(full), .gap_err(gap_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] fills [5] = '{6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b111111};
    logic [2:0] cols  [3] = '{3'd0, 3'd6, 3'd2};

    initial begin
        reset = 1'b0; go = 1'b1; onoff = 6'b000000; col_in = 3'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_row", row, 7);
            check("rst_col", col, 0);
            check("rst_valid", row_valid, 0);
            check("rst_empty", empty, 1);
            check("rst_full", full, 0);
            check("rst_gap", gap_err, 0);
        end

        reset = 1'b1; onoff = 6'b000001; col_in = 3'd3;
        tick();
        go = 1'b0;
        check("b0_row", row, 5);
        check("b0_col", col, 3);
        check("b0_valid", row_valid, 1);
        check("b0_empty", empty, 0);
        check("b0_full", full, 0);
        check("b0_gap", gap_err, 0);
        col_in = 3'd1; onoff = 6'b111111;
        tick();
        check("hold_valid", row_valid, 0);
        check("hold_row", row, 5);
        check("hold_col", col, 3);
        check("hold_full", full, 0);

        for (int i = 0; i < 5; i++) begin
            go = 1'b1; onoff = fills[i]; col_in = 3'd4;
            tick();
            go = 1'b0;
            check("fill_row", row, 4 - i);
            check("fill_full", full, i == 4);
            check("fill_gap", gap_err, 0);
            check("fill_valid", row_valid, 1);
        end

        go = 1'b1; onoff = 6'b000100;
        tick();
        check("gap_row", row, 3);
        check("gap_err", gap_err, 1);
        check("gap_empty", empty, 0);
        onoff = 6'b000000;
        tick();
        go = 1'b0;
        check("empty_row", row, 7);
        check("empty_flag", empty, 1);
        check("empty_gap", gap_err, 0);
        check("empty_full", full, 0);

        go = 1'b1; onoff = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            col_in = cols[i];
            tick();
            check("burst_valid", row_valid, 1);
            check("burst_col", col, cols[i]);
            check("burst_row", row, 3);
        end
        go = 1'b0;
        tick();
        check("burst_end_valid", row_valid, 0);

        reset = 1'b0; go = 1'b1; onoff = 6'b000011; col_in = 3'd6;
        tick();
        check("rstwin_row", row, 7);
        check("rstwin_valid", row_valid, 0);
        check("rstwin_col", col, 0);
        check("rstwin_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
